// File: rtl/bless_age_router.sv
// Bufferless age-ordered deflection router for one node of a 2D torus.
// Define BLESS_EJECT_FIFO_EN to queue ejected flits in an EJ_DEPTH-entry FIFO drained by ej_rdy.
module bless_age_router #(
  parameter int unsigned XW       = 2,
  parameter int unsigned YW       = 2,
  parameter int unsigned MY_X     = 0,
  parameter int unsigned MY_Y     = 0,
  parameter int unsigned SEQ_W    = 2,
  parameter int unsigned AGE_W    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned EJ_DEPTH = 4,
  localparam int unsigned CW      = 1 + SEQ_W + 2 * (XW + YW) + AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     n_ci,
  input  logic [CW-1:0]     e_ci,
  input  logic [CW-1:0]     s_ci,
  input  logic [CW-1:0]     w_ci,
  input  logic [DATA_W-1:0] n_di,
  input  logic [DATA_W-1:0] e_di,
  input  logic [DATA_W-1:0] s_di,
  input  logic [DATA_W-1:0] w_di,
  output logic [CW-1:0]     n_co,
  output logic [CW-1:0]     e_co,
  output logic [CW-1:0]     s_co,
  output logic [CW-1:0]     w_co,
  output logic [DATA_W-1:0] n_do,
  output logic [DATA_W-1:0] e_do,
  output logic [DATA_W-1:0] s_do,
  output logic [DATA_W-1:0] w_do,
  input  logic [CW-1:0]     inj_ci,
  input  logic [DATA_W-1:0] inj_di,
  output logic              inj_r,
  output logic [CW-1:0]     ej_co,
  output logic [DATA_W-1:0] ej_do,
  input  logic              ej_rdy
);

  localparam int unsigned AW     = XW + YW;
  localparam int unsigned DST_LO = AGE_W;
  localparam int unsigned SEQ_LO = AGE_W + 2 * AW;
  localparam logic [AW-1:0]    SELF    = {XW'(MY_X), YW'(MY_Y)};
  localparam logic [XW-1:0]    HALF_X  = XW'(1 << (XW - 1));
  localparam logic [YW-1:0]    HALF_Y  = YW'(1 << (YW - 1));
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Port encoding: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
  function automatic logic [1:0] route(input logic [AW-1:0] dest);
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    dx = dest[AW-1:YW] - XW'(MY_X);
    dy = dest[YW-1:0] - YW'(MY_Y);
    if (dx != '0) route = (dx <= HALF_X) ? 2'd1 : 2'd3;
    else          route = (dy <= HALF_Y) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [1:0] first_free(input logic [3:0] free);
    first_free = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (free[k]) first_free = 2'(k);
    end
  endfunction

  function automatic logic [CW-1:0] bump_age(input logic [CW-1:0] c);
    bump_age = c;
    if (c[AGE_W-1:0] != AGE_MAX) bump_age[AGE_W-1:0] = c[AGE_W-1:0] + AGE_W'(1);
  endfunction

  logic [CW-1:0]     in_c [5];
  logic [DATA_W-1:0] in_d [5];
  logic [CW-1:0]     nxt_c [4];
  logic [DATA_W-1:0] nxt_d [4];
  logic [CW-1:0]     out_c [4];
  logic [DATA_W-1:0] out_d [4];
  logic [1:0]        rank [4];
  logic [CW-1:0]     inj_flit;
  logic [CW-1:0]     ej_c;
  logic [DATA_W-1:0] ej_d;
  logic [3:0]        live;
  logic [3:0]        free;
  logic [2:0]        n_rem;
  logic [1:0]        ej_idx;
  logic [1:0]        want;
  logic [1:0]        port;
  logic              ej_found;
  logic              link_ej;
  logic              eject_ok;
  logic              inj_self;
  logic              inj_acc;

  assign in_c[0] = n_ci;
  assign in_c[1] = e_ci;
  assign in_c[2] = s_ci;
  assign in_c[3] = w_ci;
  assign in_c[4] = inj_ci;
  assign in_d[0] = n_di;
  assign in_d[1] = e_di;
  assign in_d[2] = s_di;
  assign in_d[3] = w_di;
  assign in_d[4] = inj_di;

  // Eject selection (oldest self-destined link flit) and inject acceptance
  always_comb begin
    ej_found = 1'b0;
    ej_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (in_c[i][CW-1] && in_c[i][DST_LO +: AW] == SELF &&
          (!ej_found || in_c[i][AGE_W-1:0] > in_c[ej_idx][AGE_W-1:0])) begin
        ej_found = 1'b1;
        ej_idx   = 2'(i);
      end
    end
    link_ej = ej_found && eject_ok;
    live    = '0;
    n_rem   = '0;
    for (int i = 0; i < 4; i++) begin
      live[i] = in_c[i][CW-1] && !(link_ej && ej_idx == 2'(i));
      n_rem   = n_rem + 3'(live[i]);
    end
    inj_self = (in_c[4][DST_LO +: AW] == SELF);
    inj_acc  = rst && in_c[4][CW-1] && (n_rem != 3'd4) &&
               (!inj_self || (!link_ej && eject_ok));
    inj_flit = {1'b1, in_c[4][SEQ_LO +: SEQ_W], SELF, in_c[4][DST_LO +: AW], AGE_W'(0)};
    ej_c = '0;
    ej_d = '0;
    if (link_ej) begin
      ej_c = in_c[ej_idx];
      ej_d = in_d[ej_idx];
    end else if (inj_acc && inj_self) begin
      ej_c = inj_flit;
      ej_d = in_d[4];
    end
  end

  assign inj_r = inj_acc;

  // Rank = number of live flits ahead: older first, then lower input index
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rank[i] = '0;
      for (int j = 0; j < 4; j++) begin
        if (live[j] && (in_c[j][AGE_W-1:0] > in_c[i][AGE_W-1:0] ||
            (in_c[j][AGE_W-1:0] == in_c[i][AGE_W-1:0] && j < i)))
          rank[i] = rank[i] + 2'd1;
      end
    end
  end

  // Port allocation in rank order; the injected flit goes last
  always_comb begin
    free = 4'hF;
    want = 2'd0;
    port = 2'd0;
    for (int p = 0; p < 4; p++) begin
      nxt_c[p] = '0;
      nxt_d[p] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (live[i] && rank[i] == 2'(p)) begin
          want = route(in_c[i][DST_LO +: AW]);
          port = (in_c[i][DST_LO +: AW] != SELF && free[want]) ? want : first_free(free);
          nxt_c[port] = bump_age(in_c[i]);
          nxt_d[port] = in_d[i];
          free[port]  = 1'b0;
        end
      end
    end
    if (inj_acc && !inj_self) begin
      want = route(in_c[4][DST_LO +: AW]);
      port = free[want] ? want : first_free(free);
      nxt_c[port] = bump_age(inj_flit);
      nxt_d[port] = in_d[4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        out_c[p] <= '0;
        out_d[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        out_c[p] <= nxt_c[p];
        out_d[p] <= nxt_d[p];
      end
    end
  end

  assign n_co = out_c[0];
  assign e_co = out_c[1];
  assign s_co = out_c[2];
  assign w_co = out_c[3];
  assign n_do = out_d[0];
  assign e_do = out_d[1];
  assign s_do = out_d[2];
  assign w_do = out_d[3];

`ifdef BLESS_EJECT_FIFO_EN
  localparam int unsigned PW = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(EJ_DEPTH);

  logic [CW-1:0]     fifo_c [EJ_DEPTH];
  logic [DATA_W-1:0] fifo_d [EJ_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       cnt;
  logic              push;
  logic              pop;

  assign push     = ej_c[CW-1];
  assign ej_co    = (cnt != '0) ? fifo_c[rd_ptr] : '0;
  assign ej_do    = (cnt != '0) ? fifo_d[rd_ptr] : '0;
  assign pop      = ej_co[CW-1] && ej_rdy;
  assign eject_ok = (cnt != FULL_CNT) || pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_c[wr_ptr] <= ej_c;
      fifo_d[wr_ptr] <= ej_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(EJ_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(EJ_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      cnt <= cnt + (PW + 1)'(push) - (PW + 1)'(pop);
    end
  end
`else
  logic [CW-1:0]     ej_c_q;
  logic [DATA_W-1:0] ej_d_q;
  logic              unused_rdy;

  assign eject_ok   = 1'b1;
  assign unused_rdy = ej_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_c_q <= '0;
      ej_d_q <= '0;
    end else begin
      ej_c_q <= ej_c;
      ej_d_q <= ej_d;
    end
  end

  assign ej_co = ej_c_q;
  assign ej_do = ej_d_q;
`endif

endmodule

// File: tb/tb_bless_age_router.sv
// Scoreboard bench for bless_age_router at node (0,0) of a 4x4 torus.
module tb_bless_age_router;

  localparam int unsigned CW = 15;

  typedef struct packed {
    logic [3:0][CW-1:0] c;
    logic [3:0][7:0]    d;
  } link_t;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [7:0]    d;
  } ej_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] n_ci, e_ci, s_ci, w_ci, inj_ci;
  logic [7:0]    n_di, e_di, s_di, w_di, inj_di;
  logic [CW-1:0] n_co, e_co, s_co, w_co, ej_co;
  logic [7:0]    n_do, e_do, s_do, w_do, ej_do;
  logic          inj_r;
  logic          ej_rdy;

  link_t link_q[$];
  ej_t   ej_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  bless_age_router #(
    .XW(2), .YW(2), .MY_X(0), .MY_Y(0), .SEQ_W(2), .AGE_W(4), .DATA_W(8), .EJ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .n_ci(n_ci), .e_ci(e_ci), .s_ci(s_ci), .w_ci(w_ci),
    .n_di(n_di), .e_di(e_di), .s_di(s_di), .w_di(w_di),
    .n_co(n_co), .e_co(e_co), .s_co(s_co), .w_co(w_co),
    .n_do(n_do), .e_do(e_do), .s_do(s_do), .w_do(w_do),
    .inj_ci(inj_ci), .inj_di(inj_di), .inj_r(inj_r),
    .ej_co(ej_co), .ej_do(ej_do), .ej_rdy(ej_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk(input logic v, input logic [1:0] seq,
                                       input logic [3:0] src, input logic [3:0] dst,
                                       input logic [3:0] age);
    mk = {v, seq, src, dst, age};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    n_ci = '0; e_ci = '0; s_ci = '0; w_ci = '0; inj_ci = '0;
    n_di = '0; e_di = '0; s_di = '0; w_di = '0; inj_di = '0;
  endtask

  task automatic exp_link(input logic [CW-1:0] cn, input logic [CW-1:0] ce,
                          input logic [CW-1:0] cs, input logic [CW-1:0] cw,
                          input logic [7:0] dn, input logic [7:0] de,
                          input logic [7:0] ds, input logic [7:0] dw);
    link_t t;
    t.c = {cw, cs, ce, cn};
    t.d = {dw, ds, de, dn};
    link_q.push_back(t);
  endtask

  task automatic exp_ej(input logic [CW-1:0] c, input logic [7:0] d);
    ej_t t;
    t.c = c;
    t.d = d;
    ej_q.push_back(t);
  endtask

  // Inputs are already applied at a negedge; check inj_r, then advance one cycle
  task automatic fire(input string nm, input logic exp_r);
    #1;
    chk(nm, 64'(inj_r), 64'(exp_r));
    @(negedge clk);
    clr();
  endtask

  // Monitor: samples after the driver settles, pops expectations on any output
  initial begin
    string pn [4];
    link_t lx;
    ej_t   ex;
    logic [3:0][CW-1:0] ac;
    logic [3:0][7:0]    ad;
    logic               ej_fire;
    pn = '{"n", "e", "s", "w"};
    forever begin
      @(negedge clk);
      #2;
      ac = {w_co, s_co, e_co, n_co};
      ad = {w_do, s_do, e_do, n_do};
      if (n_co[CW-1] || e_co[CW-1] || s_co[CW-1] || w_co[CW-1]) begin
        if (link_q.size() == 0) begin
          chk("link_unexpected", 64'({n_co[CW-1], e_co[CW-1], s_co[CW-1], w_co[CW-1]}), 64'(0));
        end else begin
          lx = link_q.pop_front();
          for (int p = 0; p < 4; p++) begin
            chk({pn[p], "_co"}, 64'(ac[p]), 64'(lx.c[p]));
            chk({pn[p], "_do"}, 64'(ad[p]), 64'(lx.d[p]));
          end
        end
      end
`ifdef BLESS_EJECT_FIFO_EN
      ej_fire = ej_co[CW-1] && ej_rdy;
`else
      ej_fire = ej_co[CW-1];
`endif
      if (ej_fire) begin
        if (ej_q.size() == 0) begin
          chk("ej_unexpected", 64'(ej_co), 64'(0));
        end else begin
          ex = ej_q.pop_front();
          chk("ej_co", 64'(ej_co), 64'(ex.c));
          chk("ej_do", 64'(ej_do), 64'(ex.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
`ifdef BLESS_EJECT_FIFO_EN
    ej_rdy = 1'b1;
`else
    ej_rdy = 1'b0;
`endif
    clr();
    inj_ci = mk(1'b1, 2'd0, 4'd0, 4'd3, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_link_c", 64'({n_co, e_co, s_co, w_co}), 64'(0));
    chk("rst_link_d", 64'({n_do, e_do, s_do, w_do}), 64'(0));
    chk("rst_ej", 64'({ej_co, ej_do}), 64'(0));
    chk("rst_inj_r", 64'(inj_r), 64'(0));
    @(negedge clk);
    clr();
    rst = 1'b1;
    @(negedge clk);

    // Inject to (0,3): one hop north, age 1, src forced to self
    inj_ci = mk(1'b1, 2'd1, 4'hF, 4'd3, 4'd9); inj_di = 8'h00;
    exp_link(mk(1'b1, 2'd1, 4'd0, 4'd3, 4'd1), '0, '0, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    fire("v1_inj_r", 1'b1);

    // Self-destined link flit ejects with age unchanged
    n_ci = mk(1'b1, 2'd2, 4'd5, 4'd0, 4'd7); n_di = 8'hA5;
    exp_ej(mk(1'b1, 2'd2, 4'd5, 4'd0, 4'd7), 8'hA5);
    fire("v2_inj_r", 1'b0);

    // Older W flit wins E; younger S flit deflects to N
    w_ci = mk(1'b1, 2'd3, 4'h6, 4'd4, 4'd5); w_di = 8'h11;
    s_ci = mk(1'b1, 2'd0, 4'h9, 4'd4, 4'd2); s_di = 8'h22;
    exp_link(mk(1'b1, 2'd0, 4'h9, 4'd4, 4'd3), mk(1'b1, 2'd3, 4'h6, 4'd4, 4'd6), '0, '0,
             8'h22, 8'h11, 8'h00, 8'h00);
    fire("v3_inj_r", 1'b0);

    // All links busy at age 15: inject refused, ages saturate, E tie at half-ring
    n_ci = mk(1'b1, 2'd0, 4'd1, 4'd4,  4'd15); n_di = 8'h01;
    e_ci = mk(1'b1, 2'd1, 4'd2, 4'd8,  4'd15); e_di = 8'h02;
    s_ci = mk(1'b1, 2'd2, 4'd3, 4'd12, 4'd15); s_di = 8'h03;
    w_ci = mk(1'b1, 2'd3, 4'd4, 4'd1,  4'd15); w_di = 8'h04;
    inj_ci = mk(1'b1, 2'd0, 4'd0, 4'd5, 4'd0); inj_di = 8'hFF;
    exp_link(mk(1'b1, 2'd1, 4'd2, 4'd8, 4'd15), mk(1'b1, 2'd0, 4'd1, 4'd4, 4'd15),
             mk(1'b1, 2'd3, 4'd4, 4'd1, 4'd15), mk(1'b1, 2'd2, 4'd3, 4'd12, 4'd15),
             8'h02, 8'h01, 8'h04, 8'h03);
    fire("v4_inj_r", 1'b0);

    // Y half-ring tie picks S; inject arbitrated after the link flit, deflects N
    e_ci = mk(1'b1, 2'd0, 4'd7, 4'd2, 4'd0); e_di = 8'h33;
    inj_ci = mk(1'b1, 2'd1, 4'd7, 4'd2, 4'd5); inj_di = 8'h44;
    exp_link(mk(1'b1, 2'd1, 4'd0, 4'd2, 4'd1), '0, mk(1'b1, 2'd0, 4'd7, 4'd2, 4'd1), '0,
             8'h44, 8'h00, 8'h33, 8'h00);
    fire("v5_inj_r", 1'b1);

    // Two self flits: older (E) ejects, other deflects; self inject refused
    n_ci = mk(1'b1, 2'd1, 4'hB, 4'd0, 4'd3); n_di = 8'h55;
    e_ci = mk(1'b1, 2'd2, 4'hC, 4'd0, 4'd9); e_di = 8'h66;
    inj_ci = mk(1'b1, 2'd0, 4'd0, 4'd0, 4'd0); inj_di = 8'h77;
    exp_ej(mk(1'b1, 2'd2, 4'hC, 4'd0, 4'd9), 8'h66);
    exp_link(mk(1'b1, 2'd1, 4'hB, 4'd0, 4'd4), '0, '0, '0, 8'h55, 8'h00, 8'h00, 8'h00);
    fire("v6_inj_r", 1'b0);

    // Self inject ejects directly with age 0 and src forced to self
    inj_ci = mk(1'b1, 2'd3, 4'hA, 4'd0, 4'd6); inj_di = 8'h88;
    exp_ej(mk(1'b1, 2'd3, 4'd0, 4'd0, 4'd0), 8'h88);
    fire("v7_inj_r", 1'b1);

    // Equal ages: S (lower index) gets W, W flit deflects N
    s_ci = mk(1'b1, 2'd0, 4'd1, 4'd12, 4'd4); s_di = 8'h99;
    w_ci = mk(1'b1, 2'd1, 4'd2, 4'd12, 4'd4); w_di = 8'hAA;
    exp_link(mk(1'b1, 2'd1, 4'd2, 4'd12, 4'd5), '0, '0, mk(1'b1, 2'd0, 4'd1, 4'd12, 4'd5),
             8'hAA, 8'h00, 8'h00, 8'h99);
    fire("v8_inj_r", 1'b0);

    // X-first routing: (1,1) goes E, (3,1) goes W over the wrap
    e_ci = mk(1'b1, 2'd2, 4'd3, 4'd5,  4'd0); e_di = 8'hBB;
    n_ci = mk(1'b1, 2'd3, 4'd4, 4'd13, 4'd0); n_di = 8'hCC;
    exp_link('0, mk(1'b1, 2'd2, 4'd3, 4'd5, 4'd1), '0, mk(1'b1, 2'd3, 4'd4, 4'd13, 4'd1),
             8'h00, 8'hBB, 8'h00, 8'hCC);
    fire("v9_inj_r", 1'b0);

    // Age 14 increments to 15
    n_ci = mk(1'b1, 2'd0, 4'd5, 4'd4, 4'd14); n_di = 8'hDD;
    exp_link('0, mk(1'b1, 2'd0, 4'd5, 4'd4, 4'd15), '0, '0, 8'h00, 8'hDD, 8'h00, 8'h00);
    fire("v10_inj_r", 1'b0);

`ifdef BLESS_EJECT_FIFO_EN
    // Park a flit in the FIFO so the reset below has something to discard
    ej_rdy = 1'b0;
    n_ci = mk(1'b1, 2'd1, 4'd3, 4'd0, 4'd2); n_di = 8'h5A;
    @(negedge clk);
    clr();
`endif
    // Reset mid-cycle with every port busy
    n_ci = mk(1'b1, 2'd0, 4'd1, 4'd4,  4'd3); n_di = 8'h01;
    e_ci = mk(1'b1, 2'd1, 4'd2, 4'd8,  4'd3); e_di = 8'h02;
    s_ci = mk(1'b1, 2'd2, 4'd3, 4'd12, 4'd3); s_di = 8'h03;
    w_ci = mk(1'b1, 2'd3, 4'd4, 4'd1,  4'd3); w_di = 8'h04;
    inj_ci = mk(1'b1, 2'd0, 4'd0, 4'd5, 4'd0); inj_di = 8'hFF;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_link_c", 64'({n_co, e_co, s_co, w_co}), 64'(0));
    chk("midrst_link_d", 64'({n_do, e_do, s_do, w_do}), 64'(0));
    chk("midrst_ej", 64'({ej_co, ej_do}), 64'(0));
    chk("midrst_inj_r", 64'(inj_r), 64'(0));
    @(negedge clk);
    clr();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_ej_empty", 64'({ej_co, ej_do}), 64'(0));
    @(negedge clk);
`ifdef BLESS_EJECT_FIFO_EN
    ej_rdy = 1'b1;
`endif

    // Traffic resumes after release
    inj_ci = mk(1'b1, 2'd2, 4'd9, 4'd3, 4'd0); inj_di = 8'h3C;
    exp_link(mk(1'b1, 2'd2, 4'd0, 4'd3, 4'd1), '0, '0, '0, 8'h3C, 8'h00, 8'h00, 8'h00);
    fire("post_inj_r", 1'b1);

`ifdef BLESS_EJECT_FIFO_EN
    // Fill the FIFO with ej_rdy low; the fifth self flit deflects
    ej_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_ci = mk(1'b1, 2'(k), 4'(k + 1), 4'd0, 4'(k + 1)); n_di = 8'(8'h10 + k);
      exp_ej(n_ci, n_di);
      fire("fill_inj_r", 1'b0);
    end
    n_ci = mk(1'b1, 2'd0, 4'd5, 4'd0, 4'd5); n_di = 8'h14;
    inj_ci = mk(1'b1, 2'd1, 4'd0, 4'd0, 4'd0); inj_di = 8'h15;
    exp_link(mk(1'b1, 2'd0, 4'd5, 4'd0, 4'd6), '0, '0, '0, 8'h14, 8'h00, 8'h00, 8'h00);
    fire("full_inj_r", 1'b0);
    ej_rdy = 1'b1;
    repeat (6) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk("link_q_left", 64'(link_q.size()), 64'(0));
    chk("ej_q_left", 64'(ej_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bless_age_router.md
BLESS_AGE_ROUTER -- requirements
Module: bless_age_router

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XW, 2, X-coordinate bits; torus is 2^XW columns.
- YW, 2, Y-coordinate bits; torus is 2^YW rows.
- MY_X, 0, this node's X.
- MY_Y, 0, this node's Y.
- SEQ_W, 2, sequence field bits.
- AGE_W, 4, age field bits.
- DATA_W, 8, payload bits.
- EJ_DEPTH, 4, ejection FIFO depth (power of 2).

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- n_ci/e_ci/s_ci/w_ci, in, CW, link control in; CW=1+SEQ_W+2*(XW+YW)+AGE_W, packed {valid,seq,src,dest,age}.
- n_di/e_di/s_di/w_di, in, DATA_W, link data in.
- n_co/e_co/s_co/w_co, out, CW, link control out.
- n_do/e_do/s_do/w_do, out, DATA_W, link data out.
- inj_ci, in, CW, resource inject control.
- inj_di, in, DATA_W, resource inject data.
- inj_r, out, 1, inject accepted this cycle.
- ej_co, out, CW, eject control.
- ej_do, out, DATA_W, eject data.
- ej_rdy, in, 1, resource can accept eject (used only with REQ-017).

REQ-003 Node address SHALL be {x,y}, with y in the LSBs.

Function
REQ-004 Link and eject outputs SHALL be registered; a flit present on an input before edge k SHALL appear on an output after edge k (one-cycle hop).
REQ-005 Directions: N = y-1 mod 2^YW, S = y+1, E = x+1, W = x-1; wrap-around is torus.
REQ-006 Productive port SHALL be chosen by X-first dimension order with the shortest torus direction; an exact half-ring tie SHALL choose E or S.
REQ-007 Arbitration order SHALL be descending age; equal ages SHALL be ordered by input index N<E<S<W.
REQ-008 In arbitration order, each flit SHALL take its productive port if free; otherwise it SHALL take the first free port in order N,E,S,W (deflection).
REQ-009 At most one flit per cycle SHALL eject: the oldest valid flit with dest == self. Further self-destined flits SHALL deflect.
REQ-010 Every flit leaving on a link SHALL have age = min(age+1, 2^AGE_W-1) (saturating); seq, src, dest and data SHALL pass through unchanged.
REQ-011 inj_r SHALL be combinational: 1 when inj_ci.valid and the count of link flits remaining after ejection is below 4, else 0.
REQ-012 An injected flit SHALL be arbitrated after all link flits, with its age forced to 0 and src forced to self.
REQ-013 A flit injected with dest == self SHALL go to eject only when no link flit ejects that cycle; otherwise inj_r SHALL be 0.
REQ-014 Unused output ports SHALL drive valid=0 and data 0.
REQ-015 No flit SHALL ever be dropped or duplicated: valid flits in (links + accepted inject) SHALL equal valid flits out (links + eject or FIFO push).

Reset
REQ-016 While rst=0: all *_co and ej_co SHALL be 0, all *_do and ej_do SHALL be 0, inj_r SHALL be 0, and the FIFO SHALL be empty; reset asserted mid-traffic SHALL discard in-flight flits immediately. Operation SHALL resume on the first edge after deassertion.

Configuration
REQ-017 With BLESS_EJECT_FIFO_EN defined:
- Ejected flits SHALL push into an EJ_DEPTH-entry FIFO.
- ej_co/ej_do SHALL show the FIFO head, which pops on the edge where ej_co.valid && ej_rdy.
- When the FIFO is full and no pop occurs this cycle, nothing SHALL eject; self-destined flits SHALL deflect.
- A simultaneous push and pop on a full FIFO SHALL be permitted.
REQ-018 Without BLESS_EJECT_FIFO_EN: eject SHALL be a one-cycle registered pulse, ej_rdy SHALL be ignored, and ejection SHALL never be blocked.

Verification
REQ-019 Node (0,0), 4x4: inject dest 3 (0,3), data 0x00 -> inj_r=1; next cycle n_co valid, dest 3, age 1, n_do 0x00.
REQ-020 Node (1,1): n_ci dest 5, age 7, data 0xA5 -> next cycle ej_co valid with age 7, ej_do 0xA5; all links idle.
REQ-021 Node (0,0): w_ci age 5 and s_ci age 2, both dest 4 (productive E) -> e_co age 6 (from w); the s flit is deflected to n_co with age 3.
REQ-022 All four link inputs valid, none for self, plus inject -> inj_r=0; all four outputs valid; ages saturate at 15 when input age is 15.
REQ-023 With BLESS_EJECT_FIFO_EN and ej_rdy=0: four self-destined flits fill the FIFO, and the fifth deflects to a link.
- Then raising ej_rdy drains the FIFO in arrival order, one per cycle.
REQ-024 rst pulled low mid-cycle with all ports busy -> all outputs 0 immediately; the FIFO is empty after release.
